// File: rtl/cache_assoc.sv
// N-way set-associative cache with multi-word lines, true-LRU replacement and
// selectable write-back/write-allocate or write-through/no-allocate policy.
module cache_assoc #(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORD_WIDTH      = 32,
  parameter int LINE_SIZE_BITS  = 2,
  parameter int LINE_COUNT_BITS = 4,
  parameter int ASSOC_BITS      = 1,
  parameter int WRITE_POLICY    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [WORD_WIDTH-1:0] mout,
  input  logic [WORD_WIDTH-1:0] min,
  output logic                  mre,
  output logic                  mwe,
  input  logic                  mready
);
  localparam int WORDS = 1 << LINE_SIZE_BITS;
  localparam int SETS  = 1 << LINE_COUNT_BITS;
  localparam int WAYS  = 1 << ASSOC_BITS;
  localparam int TAG_W = ADDR_WIDTH - LINE_SIZE_BITS - LINE_COUNT_BITS;

  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_LOOKUP = 3'd2,
                         S_WB   = 3'd3, S_FILL = 3'd4, S_WTHRU  = 3'd5;

  logic [WORD_WIDTH-1:0] data_q [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]      tag_q  [WAYS][SETS];
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [ASSOC_BITS-1:0] age_q  [SETS][WAYS];

  logic [2:0]                 state;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [WORD_WIDTH-1:0]      din_q, dout_q;
  logic                       rd_q;
  logic [LINE_COUNT_BITS-1:0] set_cnt;
  logic [LINE_SIZE_BITS-1:0]  wcnt;
  logic [ASSOC_BITS-1:0]      victim;

  logic [LINE_SIZE_BITS-1:0]  off;
  logic [LINE_COUNT_BITS-1:0] idx;
  logic [TAG_W-1:0]           tag;
  logic                       hit, accept, wthru_req, fill_last;
  logic [ASSOC_BITS-1:0]      hit_way, vict, lru_way, lru_old;
  logic                       lru_en, vict_found;

  assign off = addr_q[LINE_SIZE_BITS-1:0];
  assign idx = addr_q[LINE_SIZE_BITS +: LINE_COUNT_BITS];
  assign tag = addr_q[ADDR_WIDTH-1 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = w[ASSOC_BITS-1:0];
      end
    end
  end

  // Lowest-index invalid way wins; otherwise the oldest way.
  always_comb begin
    vict       = '0;
    vict_found = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        vict       = w[ASSOC_BITS-1:0];
        vict_found = 1'b1;
      end
    end
    if (!vict_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == '1) vict = w[ASSOC_BITS-1:0];
      end
    end
  end

  assign wthru_req = (WRITE_POLICY == 1) && !rd_q;
  assign ready     = (state == S_IDLE) || (state == S_LOOKUP && hit && !wthru_req);
  assign accept    = ready && (re || we);
  assign fill_last = (state == S_FILL) && mready && (wcnt == '1);
  assign dout      = (state == S_LOOKUP && hit && rd_q) ? data_q[hit_way][idx][off] : dout_q;

  // A freshly installed line is treated as having been the oldest, so every
  // other way ages by one and the set keeps a proper age permutation.
  always_comb begin
    lru_en  = 1'b0;
    lru_way = hit_way;
    lru_old = age_q[idx][hit_way];
    if (state == S_LOOKUP && hit) begin
      lru_en = 1'b1;
    end else if (fill_last) begin
      lru_en  = 1'b1;
      lru_way = victim;
      lru_old = '1;
    end
  end

  always_comb begin
    mre   = 1'b0;
    mwe   = 1'b0;
    maddr = '0;
    mout  = '0;
    case (state)
      S_WB: begin
        mwe   = 1'b1;
        maddr = {tag_q[victim][idx], idx, wcnt};
        mout  = data_q[victim][idx][wcnt];
      end
      S_FILL: begin
        mre   = 1'b1;
        maddr = {tag, idx, wcnt};
      end
      S_WTHRU: begin
        mwe   = 1'b1;
        maddr = addr_q;
        mout  = din_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      set_cnt <= '0;
      wcnt    <= '0;
      victim  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= addr;
        din_q  <= din;
        rd_q   <= re;
      end
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (w[ASSOC_BITS-1:0] == lru_way) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < lru_old) age_q[idx][w] <= age_q[idx][w] + ASSOC_BITS'(1);
        end
      end
      case (state)
        S_INIT: begin
          valid_q[set_cnt] <= '0;
          dirty_q[set_cnt] <= '0;
          for (int w = 0; w < WAYS; w++) age_q[set_cnt][w] <= '0;
          set_cnt <= set_cnt + LINE_COUNT_BITS'(1);
          if (set_cnt == '1) state <= S_IDLE;
        end
        S_IDLE: if (accept) state <= S_LOOKUP;
        S_LOOKUP: begin
          if (hit) begin
            if (rd_q) begin
              dout_q <= data_q[hit_way][idx][off];
            end else begin
              data_q[hit_way][idx][off] <= din_q;
              if (WRITE_POLICY == 0) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (wthru_req) state <= S_WTHRU;
            else           state <= accept ? S_LOOKUP : S_IDLE;
          end else if (wthru_req) begin
            state <= S_WTHRU;
          end else begin
            victim <= vict;
            wcnt   <= '0;
            state  <= (valid_q[idx][vict] && dirty_q[idx][vict]) ? S_WB : S_FILL;
          end
        end
        S_WB: if (mready) begin
          wcnt <= wcnt + LINE_SIZE_BITS'(1);
          if (wcnt == '1) state <= S_FILL;
        end
        S_FILL: if (mready) begin
          data_q[victim][idx][wcnt] <= min;
          wcnt <= wcnt + LINE_SIZE_BITS'(1);
          if (wcnt == '1) begin
            valid_q[idx][victim] <= 1'b1;
            dirty_q[idx][victim] <= 1'b0;
            tag_q[victim][idx]   <= tag;
            state                <= S_LOOKUP;
          end
        end
        S_WTHRU: if (mready) state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end
endmodule
